// File: rtl/ex_hazard_sequencer_if.sv
// Hazard-sequencer bundle: hazard inputs from ID/EX and pipeline controls back.
interface ex_hazard_sequencer_if #(
  parameter int unsigned CNT_W = 32
);
  logic [4:0]       id_rs1;
  logic [4:0]       id_rs2;
  logic             id_uses_rs1;
  logic             id_uses_rs2;
  logic             ex_is_lw;
  logic             ex_reg_write;
  logic [4:0]       ex_rd;
  logic             ex_md_op;
  logic             md_done;
  logic             pc_redirect;
  logic             md_start;
  logic             pc_write_en;
  logic             if_id_write_en;
  logic             if_id_flush;
  logic             id_ex_flush;
  logic             ex_hold;
  logic             ex_mem_bubble;
  logic [CNT_W-1:0] stall_count;
  logic [CNT_W-1:0] flush_count;
  logic             md_timeout_err;

  // Pipeline side: drives hazard information, consumes controls.
  modport master (
    output id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_is_lw, ex_reg_write,
           ex_rd, ex_md_op, md_done, pc_redirect,
    input  md_start, pc_write_en, if_id_write_en, if_id_flush, id_ex_flush,
           ex_hold, ex_mem_bubble, stall_count, flush_count, md_timeout_err
  );

  // Sequencer side.
  modport slave (
    input  id_rs1, id_rs2, id_uses_rs1, id_uses_rs2, ex_is_lw, ex_reg_write,
           ex_rd, ex_md_op, md_done, pc_redirect,
    output md_start, pc_write_en, if_id_write_en, if_id_flush, id_ex_flush,
           ex_hold, ex_mem_bubble, stall_count, flush_count, md_timeout_err
  );
endinterface

// File: rtl/ex_hazard_sequencer.sv
// Execute-stage hazard sequencer: load-use stalls, redirect flushes and
// multi-cycle mul/div holds, with saturating stall/flush counters.
module ex_hazard_sequencer #(
  parameter int unsigned CNT_W      = 32,
  parameter int unsigned MD_TIMEOUT = 64
) (
  input  logic                 clk,
  input  logic                 rst,
  ex_hazard_sequencer_if.slave bus
);

  localparam int unsigned TMR_W = $clog2(MD_TIMEOUT + 1);

  typedef enum logic {
    RUN     = 1'b0,
    MD_WAIT = 1'b1
  } state_t;

  state_t             state_q, state_nx;
  logic [TMR_W-1:0]   timer_q, timer_nx;
  logic [CNT_W-1:0]   stall_cnt_q, flush_cnt_q;
  logic               err_q;

  logic load_use;
  logic pc_we, ifid_we, ifid_fl, idex_fl, hold, bubble, start;
  logic redirect_take, timeout_hit;

  // Load whose result is needed by the instruction sitting in ID.
  assign load_use = bus.ex_is_lw && bus.ex_reg_write && (bus.ex_rd != 5'd0) &&
                    ((bus.id_uses_rs1 && (bus.id_rs1 == bus.ex_rd)) ||
                     (bus.id_uses_rs2 && (bus.id_rs2 == bus.ex_rd)));

  // Next state and combinational pipeline controls.
  always_comb begin
    pc_we         = 1'b1;
    ifid_we       = 1'b1;
    ifid_fl       = 1'b0;
    idex_fl       = 1'b0;
    hold          = 1'b0;
    bubble        = 1'b0;
    start         = 1'b0;
    state_nx      = state_q;
    timer_nx      = timer_q;
    redirect_take = 1'b0;
    timeout_hit   = 1'b0;
    if (rst) begin
      pc_we    = 1'b0;
      ifid_we  = 1'b0;
      ifid_fl  = 1'b1;
      idex_fl  = 1'b1;
      bubble   = 1'b1;
      state_nx = RUN;
      timer_nx = '0;
    end else begin
      case (state_q)
        RUN: begin
          if (bus.pc_redirect) begin
            ifid_fl       = 1'b1;
            idex_fl       = 1'b1;
            redirect_take = 1'b1;
          end else if (bus.ex_md_op) begin
            start    = 1'b1;
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            hold     = 1'b1;
            bubble   = 1'b1;
            timer_nx = TMR_W'(1);
            state_nx = MD_WAIT;
          end else if (load_use) begin
            pc_we   = 1'b0;
            ifid_we = 1'b0;
            idex_fl = 1'b1;
          end
        end
        MD_WAIT: begin
          if (bus.md_done) begin
            state_nx = RUN;
          end else if (timer_q == TMR_W'(MD_TIMEOUT)) begin
            timeout_hit = 1'b1;
            state_nx    = RUN;
          end else begin
            pc_we    = 1'b0;
            ifid_we  = 1'b0;
            hold     = 1'b1;
            bubble   = 1'b1;
            timer_nx = timer_q + TMR_W'(1);
          end
        end
      endcase
    end
  end

  // State, md timer, saturating counters and sticky timeout flag.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= RUN;
      timer_q     <= '0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
      err_q       <= 1'b0;
    end else begin
      state_q <= state_nx;
      timer_q <= timer_nx;
      if (!pc_we && (stall_cnt_q != '1)) stall_cnt_q <= stall_cnt_q + CNT_W'(1);
      if (redirect_take && (flush_cnt_q != '1)) flush_cnt_q <= flush_cnt_q + CNT_W'(1);
      if (timeout_hit) err_q <= 1'b1;
    end
  end

  assign bus.md_start       = start;
  assign bus.pc_write_en    = pc_we;
  assign bus.if_id_write_en = ifid_we;
  assign bus.if_id_flush    = ifid_fl;
  assign bus.id_ex_flush    = idex_fl;
  assign bus.ex_hold        = hold;
  assign bus.ex_mem_bubble  = bubble;
  assign bus.stall_count    = stall_cnt_q;
  assign bus.flush_count    = flush_cnt_q;
  assign bus.md_timeout_err = err_q;

endmodule

// File: tb/tb_ex_hazard_sequencer.sv
// Directed bench for ex_hazard_sequencer; inputs change on negedge, outputs
// are sampled 1ns later, registered effects are checked on the next negedge.
module tb_ex_hazard_sequencer;

  localparam int unsigned CNT_W      = 32;
  localparam int unsigned MD_TIMEOUT = 8;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp = 0;
  int   n_err = 0;

  ex_hazard_sequencer_if #(.CNT_W(CNT_W)) bus ();

  ex_hazard_sequencer #(.CNT_W(CNT_W), .MD_TIMEOUT(MD_TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic idle();
    bus.id_rs1 = 5'd0; bus.id_rs2 = 5'd0;
    bus.id_uses_rs1 = 1'b0; bus.id_uses_rs2 = 1'b0;
    bus.ex_is_lw = 1'b0; bus.ex_reg_write = 1'b0; bus.ex_rd = 5'd0;
    bus.ex_md_op = 1'b0; bus.md_done = 1'b0; bus.pc_redirect = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge clk); rst = 1'b1; idle();
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk); rst = 1'b1; idle(); bus.ex_md_op = 1'b1; #1;
    n_cmp++; if (bus.pc_write_en !== 1'b0) begin n_err++; $display("FAIL rst_pc_we: got %b want 0", bus.pc_write_en); end
    n_cmp++; if (bus.if_id_write_en !== 1'b0) begin n_err++; $display("FAIL rst_ifid_we: got %b want 0", bus.if_id_write_en); end
    n_cmp++; if ({bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_bubble} !== 3'b111) begin n_err++; $display("FAIL rst_flush_bubble: got %b want 111", {bus.if_id_flush, bus.id_ex_flush, bus.ex_mem_bubble}); end
    n_cmp++; if ({bus.ex_hold, bus.md_start} !== 2'b00) begin n_err++; $display("FAIL rst_hold_start: got %b want 00", {bus.ex_hold, bus.md_start}); end
    @(negedge clk);
    n_cmp++; if (bus.stall_count !== 32'd0 || bus.flush_count !== 32'd0 || bus.md_timeout_err !== 1'b0) begin n_err++; $display("FAIL rst_regs: got %0d/%0d/%b want 0/0/0", bus.stall_count, bus.flush_count, bus.md_timeout_err); end
    idle(); rst = 1'b0; #1;
    n_cmp++; if (bus.pc_write_en !== 1'b1 || bus.if_id_write_en !== 1'b1 || bus.id_ex_flush !== 1'b0 || bus.ex_mem_bubble !== 1'b0) begin n_err++; $display("FAIL run_default: got pc=%b ifid=%b idex_fl=%b bub=%b want 1 1 0 0", bus.pc_write_en, bus.if_id_write_en, bus.id_ex_flush, bus.ex_mem_bubble); end
  endtask

  task automatic test_load_use();
    do_reset();
    bus.ex_is_lw = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd5;
    bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b1; #1;
    n_cmp++; if ({bus.pc_write_en, bus.if_id_write_en, bus.id_ex_flush, bus.if_id_flush} !== 4'b0010) begin n_err++; $display("FAIL lu_rs1_ctrl: got %b want 0010", {bus.pc_write_en, bus.if_id_write_en, bus.id_ex_flush, bus.if_id_flush}); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (bus.pc_write_en !== 1'b1) begin n_err++; $display("FAIL lu_one_bubble: got %b want 1", bus.pc_write_en); end
    n_cmp++; if (bus.stall_count !== 32'd1) begin n_err++; $display("FAIL lu_stall_cnt1: got %0d want 1", bus.stall_count); end
    bus.ex_is_lw = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd17;
    bus.id_rs1 = 5'd3; bus.id_uses_rs1 = 1'b1; bus.id_rs2 = 5'd17; bus.id_uses_rs2 = 1'b1; #1;
    n_cmp++; if (bus.pc_write_en !== 1'b0 || bus.id_ex_flush !== 1'b1) begin n_err++; $display("FAIL lu_rs2_ctrl: got pc=%b fl=%b want 0 1", bus.pc_write_en, bus.id_ex_flush); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (bus.stall_count !== 32'd2) begin n_err++; $display("FAIL lu_stall_cnt2: got %0d want 2", bus.stall_count); end
  endtask

  task automatic test_no_stall();
    do_reset();
    bus.ex_is_lw = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd0;
    bus.id_rs1 = 5'd0; bus.id_uses_rs1 = 1'b1; #1;
    n_cmp++; if (bus.pc_write_en !== 1'b1 || bus.id_ex_flush !== 1'b0) begin n_err++; $display("FAIL ns_rd0: got pc=%b fl=%b want 1 0", bus.pc_write_en, bus.id_ex_flush); end
    @(negedge clk); bus.ex_rd = 5'd5; bus.id_rs1 = 5'd5; bus.id_uses_rs1 = 1'b0; bus.id_rs2 = 5'd5; bus.id_uses_rs2 = 1'b0; #1;
    n_cmp++; if (bus.pc_write_en !== 1'b1) begin n_err++; $display("FAIL ns_unused: got %b want 1", bus.pc_write_en); end
    @(negedge clk); bus.id_uses_rs1 = 1'b1; bus.ex_reg_write = 1'b0; #1;
    n_cmp++; if (bus.pc_write_en !== 1'b1) begin n_err++; $display("FAIL ns_noregwrite: got %b want 1", bus.pc_write_en); end
    @(negedge clk); bus.ex_reg_write = 1'b1; bus.ex_is_lw = 1'b0; #1;
    n_cmp++; if (bus.pc_write_en !== 1'b1) begin n_err++; $display("FAIL ns_notload: got %b want 1", bus.pc_write_en); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (bus.stall_count !== 32'd0 || bus.flush_count !== 32'd0) begin n_err++; $display("FAIL ns_counts: got %0d/%0d want 0/0", bus.stall_count, bus.flush_count); end
  endtask

  task automatic test_md();
    do_reset();
    bus.ex_md_op = 1'b1; #1;
    n_cmp++; if ({bus.md_start, bus.ex_hold, bus.ex_mem_bubble, bus.pc_write_en, bus.if_id_write_en} !== 5'b11100) begin n_err++; $display("FAIL md_start_cycle: got %b want 11100", {bus.md_start, bus.ex_hold, bus.ex_mem_bubble, bus.pc_write_en, bus.if_id_write_en}); end
    for (int c = 1; c <= 3; c++) begin
      @(negedge clk); bus.pc_redirect = (c == 2); #1;
      n_cmp++; if ({bus.md_start, bus.ex_hold, bus.ex_mem_bubble, bus.pc_write_en, bus.if_id_flush} !== 5'b01100) begin n_err++; $display("FAIL md_wait_c%0d: got %b want 01100", c, {bus.md_start, bus.ex_hold, bus.ex_mem_bubble, bus.pc_write_en, bus.if_id_flush}); end
    end
    @(negedge clk); bus.pc_redirect = 1'b0; bus.md_done = 1'b1; #1;
    n_cmp++; if ({bus.md_start, bus.ex_hold, bus.ex_mem_bubble, bus.pc_write_en, bus.if_id_write_en} !== 5'b00011) begin n_err++; $display("FAIL md_release: got %b want 00011", {bus.md_start, bus.ex_hold, bus.ex_mem_bubble, bus.pc_write_en, bus.if_id_write_en}); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (bus.stall_count !== 32'd4 || bus.flush_count !== 32'd0) begin n_err++; $display("FAIL md_counts: got %0d/%0d want 4/0", bus.stall_count, bus.flush_count); end
    n_cmp++; if (bus.ex_hold !== 1'b0 || bus.md_start !== 1'b0) begin n_err++; $display("FAIL md_back_run: got hold=%b start=%b want 0 0", bus.ex_hold, bus.md_start); end
    // md_done alongside the launch is ignored; the op still waits.
    bus.ex_md_op = 1'b1; bus.md_done = 1'b1; #1;
    n_cmp++; if (bus.md_start !== 1'b1 || bus.ex_hold !== 1'b1) begin n_err++; $display("FAIL md_early_done_launch: got start=%b hold=%b want 1 1", bus.md_start, bus.ex_hold); end
    @(negedge clk); bus.md_done = 1'b0; #1;
    n_cmp++; if (bus.ex_hold !== 1'b1 || bus.md_start !== 1'b0) begin n_err++; $display("FAIL md_early_done_wait: got hold=%b start=%b want 1 0", bus.ex_hold, bus.md_start); end
    @(negedge clk); bus.md_done = 1'b1; #1;
    n_cmp++; if (bus.ex_hold !== 1'b0) begin n_err++; $display("FAIL md_early_done_rel: got %b want 0", bus.ex_hold); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (bus.stall_count !== 32'd6) begin n_err++; $display("FAIL md_early_done_cnt: got %0d want 6", bus.stall_count); end
  endtask

  task automatic test_redirect();
    do_reset();
    bus.pc_redirect = 1'b1;
    bus.ex_is_lw = 1'b1; bus.ex_reg_write = 1'b1; bus.ex_rd = 5'd9;
    bus.id_rs1 = 5'd9; bus.id_uses_rs1 = 1'b1; bus.ex_md_op = 1'b1; #1;
    n_cmp++; if ({bus.if_id_flush, bus.id_ex_flush, bus.pc_write_en, bus.md_start, bus.ex_hold} !== 5'b11100) begin n_err++; $display("FAIL rd_ctrl: got %b want 11100", {bus.if_id_flush, bus.id_ex_flush, bus.pc_write_en, bus.md_start, bus.ex_hold}); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (bus.flush_count !== 32'd1 || bus.stall_count !== 32'd0) begin n_err++; $display("FAIL rd_counts: got %0d/%0d want 1/0", bus.flush_count, bus.stall_count); end
    bus.pc_redirect = 1'b1; @(negedge clk); bus.pc_redirect = 1'b1; #1;
    n_cmp++; if (bus.flush_count !== 32'd2) begin n_err++; $display("FAIL rd_b2b: got %0d want 2", bus.flush_count); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (bus.flush_count !== 32'd3) begin n_err++; $display("FAIL rd_b2b_total: got %0d want 3", bus.flush_count); end
  endtask

  task automatic test_timeout();
    int holds;
    do_reset();
    holds = 0;
    bus.ex_md_op = 1'b1;
    for (int c = 0; c < 8; c++) begin
      #1; if (bus.ex_hold === 1'b1) holds++;
      @(negedge clk);
    end
    #1;
    n_cmp++; if (holds !== 8) begin n_err++; $display("FAIL to_hold_cycles: got %0d want 8", holds); end
    n_cmp++; if (bus.ex_hold !== 1'b0 || bus.pc_write_en !== 1'b1 || bus.ex_mem_bubble !== 1'b0) begin n_err++; $display("FAIL to_release: got hold=%b pc=%b bub=%b want 0 1 0", bus.ex_hold, bus.pc_write_en, bus.ex_mem_bubble); end
    n_cmp++; if (bus.md_timeout_err !== 1'b0) begin n_err++; $display("FAIL to_err_early: got %b want 0", bus.md_timeout_err); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (bus.md_timeout_err !== 1'b1 || bus.stall_count !== 32'd8) begin n_err++; $display("FAIL to_err_set: got err=%b stall=%0d want 1 8", bus.md_timeout_err, bus.stall_count); end
    repeat (3) @(negedge clk); #1;
    n_cmp++; if (bus.md_timeout_err !== 1'b1) begin n_err++; $display("FAIL to_err_sticky: got %b want 1", bus.md_timeout_err); end
    do_reset(); #1;
    n_cmp++; if (bus.md_timeout_err !== 1'b0) begin n_err++; $display("FAIL to_err_clear: got %b want 0", bus.md_timeout_err); end
  endtask

  task automatic test_reset_mid_md();
    do_reset();
    bus.ex_md_op = 1'b1; bus.pc_redirect = 1'b0;
    @(negedge clk); bus.ex_md_op = 1'b0;
    @(negedge clk); #1;
    n_cmp++; if (bus.ex_hold !== 1'b1) begin n_err++; $display("FAIL rm_in_wait: got %b want 1", bus.ex_hold); end
    rst = 1'b1; #1;
    n_cmp++; if (bus.md_start !== 1'b0 || bus.ex_hold !== 1'b0 || bus.pc_write_en !== 1'b0) begin n_err++; $display("FAIL rm_rst_ctrl: got start=%b hold=%b pc=%b want 0 0 0", bus.md_start, bus.ex_hold, bus.pc_write_en); end
    @(negedge clk); rst = 1'b0; #1;
    n_cmp++; if (bus.pc_write_en !== 1'b1 || bus.ex_hold !== 1'b0 || bus.md_start !== 1'b0) begin n_err++; $display("FAIL rm_run: got pc=%b hold=%b start=%b want 1 0 0", bus.pc_write_en, bus.ex_hold, bus.md_start); end
    n_cmp++; if (bus.stall_count !== 32'd0 || bus.flush_count !== 32'd0) begin n_err++; $display("FAIL rm_counts: got %0d/%0d want 0/0", bus.stall_count, bus.flush_count); end
    @(negedge clk); bus.md_done = 1'b1; #1;
    n_cmp++; if (bus.pc_write_en !== 1'b1 || bus.md_start !== 1'b0 || bus.ex_hold !== 1'b0) begin n_err++; $display("FAIL rm_done_ignored: got pc=%b start=%b hold=%b want 1 0 0", bus.pc_write_en, bus.md_start, bus.ex_hold); end
    @(negedge clk); idle(); #1;
    n_cmp++; if (bus.stall_count !== 32'd0 || bus.md_timeout_err !== 1'b0) begin n_err++; $display("FAIL rm_final: got stall=%0d err=%b want 0 0", bus.stall_count, bus.md_timeout_err); end
  endtask

  initial begin
    idle();
    test_reset();
    test_load_use();
    test_no_stall();
    test_md();
    test_redirect();
    test_timeout();
    test_reset_mid_md();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
